// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and helpers for the LCD bus scheduler.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_WAIT    = 3'd5
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;

  localparam logic [1:0] LCD_INIT_LAST = 2'd3;

  function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNCSET;
      2'd1:    return LCD_CMD_DISPON;
      2'd2:    return LCD_CMD_CLEAR;
      default: return LCD_CMD_ENTRY;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic lcd_is_long(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Round-robin grant among byte-write requesters; the last-grant pointer moves only on an accepted grant.
module lcd_rr_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic [IW-1:0] last;
  logic [IW-1:0] cand;

  // Search starts one past the last winner and wraps.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= IW'(NUM_REQ - 1);
    end else if (take) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Owns the HD44780 8-bit bus: power-up init sequence, then round-robin byte writes
// with setup / enable / hold / execution-wait timing.
//
// state   | meaning
// POWERUP | wait for the panel to power up after reset
// IDLE    | bus parked, arbitrate requesters once init is done
// SETUP   | RS/data stable, EN low
// PULSE   | EN high
// HOLD    | EN low, RS/data still held
// WAIT    | execution time of the command just written
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_BITS = 8,
  parameter int T_POWERUP = 800_000,
  parameter int T_SETUP   = 2,
  parameter int T_EN_HIGH = 25,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 2_500,
  parameter int T_LONG    = 82_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_rs,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         done,
  output logic                         busy,
  output logic                         init_done,
  output logic [DATA_BITS-1:0]         lcd_data,
  output logic                         lcd_rs,
  output logic                         lcd_rw,
  output logic                         lcd_en
);

  localparam int CW = $clog2(lcd_max(T_POWERUP, T_LONG) + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CW-1:0] LD_PU    = CW'((T_POWERUP > 1) ? T_POWERUP - 1 : 0);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN_HIGH);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC);
  localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG);

  lcd_state_e           state, state_next;
  logic [CW-1:0]        cnt;
  logic [1:0]           init_idx;
  logic                 cnt_last;
  logic                 pu_exit;
  logic                 take;
  logic [CW-1:0]        wait_load;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [DATA_BITS-1:0] sel_data;
  logic                 sel_rs;

  lcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .take  (take),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign cnt_last  = (cnt == CW'(1));
  // The counter comes out of reset at 0, so the first POWERUP cycle loads it.
  assign pu_exit   = (state == ST_POWERUP) && (cnt_last || ((cnt == '0) && (T_POWERUP <= 1)));
  assign take      = (state == ST_IDLE) && init_done && arb_valid;
  assign sel_data  = req_data[int'(arb_idx)*DATA_BITS +: DATA_BITS];
  assign sel_rs    = req_rs[arb_idx];
  assign wait_load = lcd_is_long(lcd_rs, 8'(lcd_data)) ? LD_LONG : LD_EXEC;
  assign lcd_rw    = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_POWERUP;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_POWERUP: if (pu_exit)  state_next = ST_SETUP;
      ST_IDLE:    if (take)     state_next = ST_SETUP;
      ST_SETUP:   if (cnt_last) state_next = ST_PULSE;
      ST_PULSE:   if (cnt_last) state_next = ST_HOLD;
      ST_HOLD:    if (cnt_last) state_next = ST_WAIT;
      ST_WAIT: begin
        if (cnt_last) begin
          if (init_done || (init_idx == LCD_INIT_LAST)) state_next = ST_IDLE;
          else                                          state_next = ST_SETUP;
        end
      end
      default:    state_next = ST_POWERUP;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state_next != state) begin
      case (state_next)
        ST_SETUP: cnt <= LD_SETUP;
        ST_PULSE: cnt <= LD_EN;
        ST_HOLD:  cnt <= LD_HOLD;
        ST_WAIT:  cnt <= wait_load;
        default:  cnt <= '0;
      endcase
    end else if ((state == ST_POWERUP) && (cnt == '0)) begin
      cnt <= LD_PU;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_data  <= '0;
      lcd_rs    <= 1'b0;
      init_idx  <= 2'd0;
      init_done <= 1'b0;
    end else if (pu_exit) begin
      lcd_data <= DATA_BITS'(lcd_init_cmd(2'd0));
      lcd_rs   <= 1'b0;
      init_idx <= 2'd0;
    end else if (take) begin
      lcd_data <= sel_data;
      lcd_rs   <= sel_rs;
    end else if ((state == ST_WAIT) && cnt_last && !init_done) begin
      if (init_idx == LCD_INIT_LAST) begin
        init_done <= 1'b1;
      end else begin
        init_idx <= init_idx + 2'd1;
        lcd_data <= DATA_BITS'(lcd_init_cmd(init_idx + 2'd1));
      end
    end
  end

  // Registered strobes keep EN glitch-free; async reset still drops it at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt    <= '0;
      done   <= 1'b0;
      lcd_en <= 1'b0;
    end else begin
      gnt    <= take ? arb_gnt : '0;
      done   <= (state == ST_WAIT) && cnt_last;
      lcd_en <= (state_next == ST_PULSE);
    end
  end

endmodule
